// File: rtl/booth_mult_seq_if.sv
// Handshake bundle for booth_mult_seq.
//   master: producer/consumer side (drives operands, mode and out_ready)
//   slave : multiplier side (drives in_ready, out_valid, out_product, busy)
// Signals:
//   in_valid/in_ready     operand handshake
//   in_signed             1 = two's complement operands, 0 = unsigned
//   in_q, in_m            multiplier, multiplicand (WIDTH bits)
//   out_valid/out_ready   product handshake
//   out_product           2*WIDTH-bit product
//   busy                  multiplier is computing or holding a result
interface booth_mult_seq_if #(
    parameter int unsigned WIDTH = 8
);
    logic                 in_valid;
    logic                 in_ready;
    logic                 in_signed;
    logic [WIDTH-1:0]     in_q;
    logic [WIDTH-1:0]     in_m;
    logic                 out_valid;
    logic                 out_ready;
    logic [2*WIDTH-1:0]   out_product;
    logic                 busy;

    modport master (
        output in_valid, in_signed, in_q, in_m, out_ready,
        input  in_ready, out_valid, out_product, busy
    );

    modport slave (
        input  in_valid, in_signed, in_q, in_m, out_ready,
        output in_ready, out_valid, out_product, busy
    );
endinterface

// File: rtl/booth_mult_seq.sv
// Sequential radix-2 Booth multiplier, one Booth step per clock.
// A WIDTH-bit multiply takes WIDTH+1 steps on WIDTH+1-bit extended operands,
// so signed and unsigned modes share one datapath.
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    booth_mult_seq_if slave modport (operand/product handshakes, busy)
module booth_mult_seq #(
    parameter int unsigned WIDTH = 8
) (
    input logic             clk,
    input logic             rst_n,
    booth_mult_seq_if.slave bus
);

    localparam int unsigned CntW = $clog2(WIDTH + 2);

    typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

    state_e               state_q, state_d;
    logic [WIDTH+1:0]     a_q, a_d;      // accumulator, one guard bit beyond M
    logic [WIDTH:0]       qr_q, qr_d;    // extended multiplier
    logic [WIDTH:0]       m_q, m_d;      // extended multiplicand
    logic                 q1_q, q1_d;
    logic [CntW-1:0]      cnt_q, cnt_d;
    logic [2*WIDTH-1:0]   prod_q, prod_d;

    logic [WIDTH+1:0]     m_ext;
    logic [WIDTH+1:0]     a_sum;
    logic [WIDTH+1:0]     a_shift;
    logic [WIDTH:0]       qr_shift;

    // One Booth step: add/subtract M, then arithmetic shift of {A, Q, q_1}.
    always_comb begin
        m_ext = {m_q[WIDTH], m_q};
        unique case ({qr_q[0], q1_q})
            2'b01:   a_sum = a_q + m_ext;
            2'b10:   a_sum = a_q - m_ext;
            default: a_sum = a_q;
        endcase
        a_shift  = {a_sum[WIDTH+1], a_sum[WIDTH+1:1]};
        qr_shift = {a_sum[0], qr_q[WIDTH:1]};
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        qr_d    = qr_q;
        m_d     = m_q;
        q1_d    = q1_q;
        cnt_d   = cnt_q;
        prod_d  = prod_q;
        unique case (state_q)
            StIdle: begin
                if (bus.in_valid) begin
                    m_d     = bus.in_signed ? {bus.in_m[WIDTH-1], bus.in_m} : {1'b0, bus.in_m};
                    qr_d    = bus.in_signed ? {bus.in_q[WIDTH-1], bus.in_q} : {1'b0, bus.in_q};
                    a_d     = '0;
                    q1_d    = 1'b0;
                    cnt_d   = '0;
                    state_d = StCalc;
                end
            end
            StCalc: begin
                a_d   = a_shift;
                qr_d  = qr_shift;
                q1_d  = qr_q[0];
                cnt_d = cnt_q + 1'b1;
                // Last of the WIDTH+1 steps: low 2*WIDTH bits of {A, Q} are the product.
                if (cnt_q == CntW'(WIDTH)) begin
                    prod_d  = {a_shift[WIDTH-2:0], qr_shift};
                    state_d = StDone;
                end
            end
            StDone: begin
                if (bus.out_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            a_q     <= '0;
            qr_q    <= '0;
            m_q     <= '0;
            q1_q    <= 1'b0;
            cnt_q   <= '0;
            prod_q  <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            qr_q    <= qr_d;
            m_q     <= m_d;
            q1_q    <= q1_d;
            cnt_q   <= cnt_d;
            prod_q  <= prod_d;
        end
    end

    assign bus.in_ready    = (state_q == StIdle);
    assign bus.out_valid   = (state_q == StDone);
    assign bus.busy        = (state_q != StIdle);
    assign bus.out_product = prod_q;

endmodule
